// File: rtl/arr_port_if.sv
// rtl/arr_port_if.sv - requester and array-port bundle for the shared-array arbiter
interface arr_port_if #(
    parameter int NREQ = 2,
    parameter int AW   = 10,
    parameter int DW   = 27
);
    logic                 host_prio;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      we;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rvalid;
    logic [DW-1:0]        rdata;
    logic                 rerr;
    logic [15:0]          err_cnt;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;

    // Arbiter side: consumes requests and array read data, drives grants and the array port.
    modport slave (
        input  host_prio, req, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, rerr, err_cnt, mem_we, mem_addr, mem_wdata
    );

    // Requester/array side.
    modport master (
        output host_prio, req, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, rerr, err_cnt, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/arr_port_arbiter.sv
// rtl/arr_port_arbiter.sv - round-robin arbiter sharing one synchronous-read array port
module arr_port_arbiter #(
    parameter int NREQ  = 2,
    parameter int AW    = 10,
    parameter int DW    = 27,
    parameter int DEPTH = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    arr_port_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] gidx;
    logic          gv;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_we;
    logic          in_range;

    logic          pend_v;
    logic [IW-1:0] pend_idx;
    logic          pend_err;
    logic [15:0]   err_cnt_q;

    // Pick the winner: host override first, else the first requester after the last winner.
    always_comb begin
        int idx;
        gv   = 1'b0;
        gidx = '0;
        idx  = 0;
        if (bus.host_prio && bus.req[0]) begin
            gv   = 1'b1;
            gidx = '0;
        end else begin
            // Descending scan so the smallest distance from ptr is written last and wins.
            for (int k = NREQ; k >= 1; k--) begin
                idx = (int'(ptr) + k) % NREQ;
                if (bus.req[idx]) begin
                    gv   = 1'b1;
                    gidx = IW'(idx);
                end
            end
        end
    end

    // Route the winner's command onto the array port; out-of-range accesses never reach memory.
    always_comb begin
        sel_addr      = bus.addr[int'(gidx)*AW +: AW];
        sel_wdata     = bus.wdata[int'(gidx)*DW +: DW];
        sel_we        = bus.we[gidx];
        in_range      = (32'(sel_addr) < 32'(DEPTH));
        bus.gnt       = gv ? (NREQ'(1) << gidx) : '0;
        bus.mem_we    = gv && sel_we && in_range;
        bus.mem_addr  = (gv && in_range) ? sel_addr : '0;
        bus.mem_wdata = gv ? sel_wdata : '0;
    end

    // Round-robin pointer and the one-deep read-return tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= IW'(NREQ - 1);
            pend_v   <= 1'b0;
            pend_idx <= '0;
            pend_err <= 1'b0;
        end else begin
            pend_v   <= gv && !sel_we;
            pend_idx <= gidx;
            pend_err <= !in_range;
            if (gv) begin
                ptr <= gidx;
            end
        end
    end

    // Saturating count of rejected (out-of-range) accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (gv && !in_range && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    // Read return: array data passes straight through, masked to zero for rejected or idle slots.
    always_comb begin
        bus.rvalid  = pend_v ? (NREQ'(1) << pend_idx) : '0;
        bus.rerr    = pend_v && pend_err;
        bus.rdata   = (pend_v && !pend_err) ? bus.mem_rdata : '0;
        bus.err_cnt = err_cnt_q;
    end
endmodule

// File: tb/tb_arr_port_arbiter.sv
// tb/tb_arr_port_arbiter.sv - randomized self-checking bench for arr_port_arbiter
module tb_arr_port_arbiter;
    localparam int NREQ  = 2;
    localparam int AW    = 10;
    localparam int DW    = 27;
    localparam int DEPTH = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arr_port_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    arr_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // The shared array itself: one port, synchronous read.
    logic [DW-1:0] arr [0:(1<<AW)-1];
    logic [DW-1:0] arr_rd;
    always @(posedge clk) begin
        if (bus.mem_we) arr[bus.mem_addr] <= bus.mem_wdata;
        arr_rd <= arr[bus.mem_addr];
    end
    assign bus.mem_rdata = arr_rd;

    // Reference model state.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            m_ptr;
    int            m_err;
    bit            m_pv;
    int            m_pidx;
    bit            m_perr;
    logic [DW-1:0] m_pdata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (bus.host_prio && bus.req[0]) return 0;
        for (int k = 1; k <= NREQ; k++) begin
            if (bus.req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = NREQ - 1;
        m_err = 0;
        m_pv  = 0;
    endtask

    // Check one cycle at the falling edge, then advance the model and the clock.
    task automatic tick();
        int            g;
        logic [AW-1:0] a;
        bit            inr;
        bit            w;
        @(negedge clk);
        chk("rvalid", 32'(bus.rvalid), m_pv ? (32'd1 << m_pidx) : 32'd0);
        if (m_pv) begin
            chk("rerr", 32'(bus.rerr), 32'(m_perr));
            chk("rdata", 32'(bus.rdata), 32'(m_pdata));
        end
        chk("err_cnt", 32'(bus.err_cnt), 32'(m_err));
        g = model_grant();
        if (g < 0) begin
            chk("gnt_idle", 32'(bus.gnt), 32'd0);
            chk("mem_we_idle", 32'(bus.mem_we), 32'd0);
            chk("mem_addr_idle", 32'(bus.mem_addr), 32'd0);
            chk("mem_wdata_idle", 32'(bus.mem_wdata), 32'd0);
            m_pv = 0;
        end else begin
            a   = bus.addr[g*AW +: AW];
            w   = bus.we[g];
            inr = (int'(a) < DEPTH);
            chk("gnt", 32'(bus.gnt), 32'd1 << g);
            chk("mem_we", 32'(bus.mem_we), 32'(w && inr));
            chk("mem_addr", 32'(bus.mem_addr), inr ? 32'(a) : 32'd0);
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(bus.wdata[g*DW +: DW]));
            m_ptr = g;
            if (!inr && m_err < 65535) m_err++;
            if (w && inr) ref_mem[a] = bus.wdata[g*DW +: DW];
            m_pv    = !w;
            m_pidx  = g;
            m_perr  = !inr;
            m_pdata = inr ? ref_mem[a] : '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hp, input logic [1:0] r, input logic [1:0] w,
                         input int a0, input int a1, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bus.host_prio = hp;
        bus.req       = r;
        bus.we        = w;
        bus.addr      = {AW'(a1), AW'(a0)};
        bus.wdata     = {d1, d0};
    endtask

    initial begin
        int n;
        for (int i = 0; i < (1 << AW); i++) begin
            arr[i]     = DW'($urandom);
            ref_mem[i] = arr[i];
        end
        drive(1'b0, 2'b00, 2'b00, 0, 0, '0, '0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_rerr", 32'(bus.rerr), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two readers alternate; requester 0 wins first.
        drive(1'b0, 2'b11, 2'b00, 5, 7, '0, '0);
        tick();
        chk("t1_rdata0", 32'(bus.rdata), 32'(ref_mem[5]));
        tick();
        chk("t1_rdata1", 32'(bus.rdata), 32'(ref_mem[7]));
        tick();
        tick();
        drive(1'b0, 2'b00, 2'b00, 0, 0, '0, '0);
        tick();

        // Write then read-after-write of the same address.
        drive(1'b0, 2'b10, 2'b10, 0, 12, '0, 27'h7FFFFFF);
        tick();
        drive(1'b0, 2'b01, 2'b00, 12, 0, '0, '0);
        tick();
        chk("t2_rvalid", 32'(bus.rvalid), 32'h1);
        chk("t2_rdata", 32'(bus.rdata), 32'h7FFFFFF);

        // Host priority starves requester 1 until dropped.
        drive(1'b1, 2'b11, 2'b00, 3, 4, '0, '0);
        repeat (5) tick();
        bus.host_prio = 1'b0;
        #1;
        chk("t3_hp_drop", 32'(bus.gnt), 32'h2);
        tick();

        // Out-of-range read and write.
        drive(1'b0, 2'b10, 2'b00, 0, 1000, '0, '0);
        #1;
        chk("t4_gnt", 32'(bus.gnt), 32'h2);
        chk("t4_mem_we", 32'(bus.mem_we), 32'h0);
        chk("t4_mem_addr", 32'(bus.mem_addr), 32'h0);
        tick();
        chk("t4_rvalid", 32'(bus.rvalid), 32'h2);
        chk("t4_rerr", 32'(bus.rerr), 32'h1);
        chk("t4_rdata", 32'(bus.rdata), 32'h0);
        chk("t4_err1", 32'(bus.err_cnt), 32'd1);
        drive(1'b0, 2'b10, 2'b10, 0, 1023, '0, 27'h1234567);
        tick();
        chk("t4_wr_rvalid", 32'(bus.rvalid), 32'h0);
        chk("t4_err2", 32'(bus.err_cnt), 32'd2);
        chk("t4_mem1023", 32'(arr[1023]), 32'(ref_mem[1023]));

        // Reset while a read is pending.
        drive(1'b0, 2'b01, 2'b00, 3, 0, '0, '0);
        tick();
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 0, 0, '0, '0);
        model_reset();
        #2;
        chk("t5_rvalid_rst", 32'(bus.rvalid), 32'h0);
        chk("t5_err_rst", 32'(bus.err_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_rvalid_after", 32'(bus.rvalid), 32'h0);
        drive(1'b0, 2'b11, 2'b00, 8, 9, '0, '0);
        #1;
        chk("t5_first_gnt", 32'(bus.gnt), 32'h1);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            int a0, a1;
            a0 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH, (1 << AW) - 1)) : int'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH, (1 << AW) - 1)) : int'($urandom_range(0, 15));
            drive(($urandom_range(0, 3) == 0), 2'($urandom), 2'($urandom), a0, a1,
                  DW'($urandom), DW'($urandom));
            tick();
        end

        // Drive the error counter up to saturation.
        n = 65534 - m_err;
        drive(1'b0, 2'b01, 2'b01, 1010, 0, '0, '0);
        for (int i = 0; i < n; i++) tick();
        chk("t6_fffe", 32'(bus.err_cnt), 32'hFFFE);
        repeat (3) tick();
        chk("t6_sat", 32'(bus.err_cnt), 32'hFFFF);
        drive(1'b0, 2'b00, 2'b00, 0, 0, '0, '0);
        tick();
        chk("t6_hold", 32'(bus.err_cnt), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
